// File: rtl/seg7_pkg.sv
// Shared definitions for blocks that drive or read a 7-segment display bus.
// Segment bit order is g..a (bit0 = a, bit6 = g), active-high.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Sequence-tracking state of the monitor: no digit yet, one digit seen
  // (no interval measurable), or at least two digits seen.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FIRST  = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the seg7 encoder: maps a segment pattern back to
// its BCD digit. Any pattern that is not one of the ten digit codes (blank
// included) reports valid = 0 and digit = 0.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] digit
);

  // Exact-match lookup against the ten digit codes
  always_comb begin
    valid = 1'b1;
    digit = 4'd0;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_monitor.sv
// Receive-side monitor for a 7-segment counter display. Synchronizes the
// bus, accepts a pattern once it has been stable long enough, decodes it,
// checks the 0..9 counting sequence and measures the cycle count between
// successive digit changes.
//
// digit_stb is a one-cycle event (no back-pressure): it is high for exactly
// the cycle after a valid pattern is accepted, and digit/period/flags are
// already updated during that cycle.
module seg7_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  input  logic                clear,
  output logic [3:0]          digit,
  output logic                digit_valid,
  output logic                digit_stb,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                seq_error,
  output logic                bad_pattern,
  output logic [1:0]          fsm_state
);

  localparam logic [7:0]          STAB_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] PCNT_MAX = {PERIOD_W{1'b1}};
  localparam logic [PERIOD_W-1:0] PCNT_ONE = PERIOD_W'(1);

  logic [6:0]          s1, s2, cand, acc;
  logic [7:0]          stab;
  logic [PERIOD_W-1:0] pcnt;
  mon_state_t          state, state_next, eff_state;

  logic       accept, acc_valid, acc_bad;
  logic       dec_valid;
  logic [3:0] dec_digit;
  logic [3:0] next_exp;

  seg7_decode u_decode (
    .seg   (cand),
    .valid (dec_valid),
    .digit (dec_digit)
  );

  // One event per newly stable pattern; re-settling on the already accepted
  // pattern (after a short glitch) does not fire again.
  assign accept    = (stab == STAB_MAX) && (cand == s2) && (cand != acc);
  assign acc_valid = accept && dec_valid;
  assign acc_bad   = accept && !dec_valid;
  assign next_exp  = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
  assign fsm_state = state;

  // Two-flop synchronizer and stability filter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      acc  <= '0;
      stab <= '0;
    end else begin
      s1 <= seg_in;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        stab <= '0;
      end else if (stab < STAB_MAX) begin
        stab <= stab + 8'd1;
      end
      if (accept) acc <= cand;
    end
  end

  // State the accept sees: a simultaneous clear makes it the first digit
  always_comb begin
    eff_state  = clear ? EMPTY : state;
    state_next = eff_state;
    if (acc_valid) state_next = (eff_state == EMPTY) ? FIRST : LOCKED;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Period counter: restarts at 1 on each valid digit, saturates otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                pcnt <= '0;
    else if (acc_valid)       pcnt <= PCNT_ONE;
    else if (clear)           pcnt <= '0;
    else if (pcnt != PCNT_MAX) pcnt <= pcnt + PCNT_ONE;
  end

  // Digit, strobe, period capture and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit        <= '0;
      digit_valid  <= 1'b0;
      digit_stb    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      seq_error    <= 1'b0;
      bad_pattern  <= 1'b0;
    end else begin
      digit_stb <= acc_valid;
      if (clear) begin
        seq_error    <= 1'b0;
        bad_pattern  <= 1'b0;
        period       <= '0;
        period_valid <= 1'b0;
      end
      if (acc_valid) begin
        digit       <= dec_digit;
        digit_valid <= 1'b1;
        if (eff_state != EMPTY) begin
          period       <= pcnt;
          period_valid <= 1'b1;
          if (dec_digit != next_exp) seq_error <= 1'b1;
        end
      end
      // Invalid pattern leaves digit, FSM and period counter alone
      if (acc_bad) begin
        bad_pattern <= 1'b1;
        digit_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_monitor.sv
// Directed bench for seg7_monitor: counting sequence, glitch rejection,
// invalid patterns, clear/accept collision, period saturation and reset.
module tb_seg7_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic        clear;

  logic [3:0]  digit;
  logic        digit_valid, digit_stb, period_valid, seq_error, bad_pattern;
  logic [23:0] period;
  logic [1:0]  fsm_state;

  logic [3:0]  sm_digit;
  logic        sm_digit_valid, sm_digit_stb, sm_period_valid, sm_seq_error, sm_bad_pattern;
  logic [7:0]  sm_period;
  logic [1:0]  sm_fsm_state;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seg7_monitor #(.STABLE_CYCLES(16), .PERIOD_W(24)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .clear(clear),
    .digit(digit), .digit_valid(digit_valid), .digit_stb(digit_stb),
    .period(period), .period_valid(period_valid), .seq_error(seq_error),
    .bad_pattern(bad_pattern), .fsm_state(fsm_state)
  );

  seg7_monitor #(.STABLE_CYCLES(16), .PERIOD_W(8)) dut_small (
    .clk(clk), .reset(reset), .seg_in(seg_in), .clear(clear),
    .digit(sm_digit), .digit_valid(sm_digit_valid), .digit_stb(sm_digit_stb),
    .period(sm_period), .period_valid(sm_period_valid), .seq_error(sm_seq_error),
    .bad_pattern(sm_bad_pattern), .fsm_state(sm_fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives code, waits 'cycles' posedges, ends at a
  // negedge. lat = posedges after the first sampling edge until the strobe.
  task automatic hold(input logic [6:0] code, input int cycles, output int lat);
    seg_in = code;
    lat = -1;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk); #1;
      if (digit_stb && lat < 0) lat = k - 1;
    end
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digit"},  digit, 0);
    check({tag, "_dvalid"}, digit_valid, 0);
    check({tag, "_stb"},    digit_stb, 0);
    check({tag, "_period"}, period, 0);
    check({tag, "_pvalid"}, period_valid, 0);
    check({tag, "_seqerr"}, seq_error, 0);
    check({tag, "_bad"},    bad_pattern, 0);
    check({tag, "_state"},  fsm_state, 0);
  endtask

  // Scoreboard: every strobe must match the next expected digit
  always @(negedge clk) begin
    if (!reset && digit_stb) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL stb_unexpected: observed digit=%0d expected no strobe", digit);
      end
      if (exp_q.size() != 0) check("stb_digit", digit, exp_q.pop_front());
    end
  end

  initial begin
    int lat;
    reset  = 1'b1;
    seg_in = 7'h00;
    clear  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("blank_no_event_state", fsm_state, 0);

    // Counting sequence 0..9,0 each held 1000 cycles
    for (int i = 0; i <= 10; i++) begin
      exp_q.push_back(4'(i % 10));
      hold(seg_tab[i % 10], 1000, lat);
      check($sformatf("seq_lat_%0d", i), lat, 18);
      check($sformatf("seq_digit_%0d", i), digit, i % 10);
      if (i == 0) check("seq_pvalid_first", period_valid, 0);
      else        check($sformatf("seq_period_%0d", i), period, 1000);
    end
    check("seq_pvalid", period_valid, 1);
    check("seq_seqerr", seq_error, 0);
    check("seq_bad", bad_pattern, 0);
    check("seq_state", fsm_state, 2);
    check("small_period_sat", sm_period, 255);
    check("small_pvalid", sm_period_valid, 1);

    // Glitch rejection: short 8 on a stable 3, then a real 8
    pulse_clear();
    check("clr_state", fsm_state, 0);
    check("clr_pvalid", period_valid, 0);
    exp_q.push_back(4'd3);
    hold(seg_tab[3], 100, lat);
    check("g3_seqerr", seq_error, 0);
    hold(seg_tab[8], 15, lat);
    hold(seg_tab[3], 100, lat);
    check("glitch_no_stb", lat, -1);
    check("glitch_digit", digit, 3);
    exp_q.push_back(4'd8);
    hold(seg_tab[8], 40, lat);
    check("g8_digit", digit, 8);
    check("g8_seqerr", seq_error, 1);

    // Blank between 5 and 6
    pulse_clear();
    check("clr2_seqerr", seq_error, 0);
    exp_q.push_back(4'd5);
    hold(seg_tab[5], 100, lat);
    hold(7'h00, 100, lat);
    check("blank_bad", bad_pattern, 1);
    check("blank_dvalid", digit_valid, 0);
    check("blank_digit", digit, 5);
    check("blank_no_stb", lat, -1);
    exp_q.push_back(4'd6);
    hold(seg_tab[6], 100, lat);
    check("b6_lat", lat, 18);
    check("b6_seqerr", seq_error, 0);
    check("b6_period", period, 200);
    check("b6_pvalid", period_valid, 1);
    check("b6_dvalid", digit_valid, 1);
    check("b6_bad_sticky", bad_pattern, 1);

    // Clear on the same edge as the accept of 7 after 4
    pulse_clear();
    exp_q.push_back(4'd4);
    hold(seg_tab[4], 100, lat);
    seg_in = seg_tab[7];
    exp_q.push_back(4'd7);
    repeat (18) @(posedge clk);
    #1 check("c7_no_early_stb", digit_stb, 0);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    check("c7_stb", digit_stb, 1);
    check("c7_digit", digit, 7);
    check("c7_seqerr", seq_error, 0);
    check("c7_pvalid", period_valid, 0);
    check("c7_state", fsm_state, 1);
    @(negedge clk);
    clear = 1'b0;
    repeat (81) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(4'd8);
    hold(seg_tab[8], 100, lat);
    check("c8_period", period, 100);
    check("c8_pvalid", period_valid, 1);
    check("c8_seqerr", seq_error, 0);
    check("c8_state", fsm_state, 2);

    // Asynchronous reset while the filter is counting a new 2
    seg_in = seg_tab[2];
    repeat (13) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(4'd2);
    hold(seg_tab[2], 100, lat);
    check("post_reset_lat", lat, 18);
    check("post_reset_digit", digit, 2);
    check("post_reset_state", fsm_state, 1);
    check("post_reset_pvalid", period_valid, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
